// File: rtl/spi_peripheral_sync.sv
// SPI peripheral clocked entirely by i_clk: oversampled SCLK/CS_N/COPI, all four
// SPI modes, back-to-back words per chip-select window, ready/valid TX holding register.
module spi_peripheral_sync #(
    parameter int WIDTH       = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_dv,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_dv,
    output logic             o_tx_ready,
    output logic             o_tx_underrun,
    output logic             o_busy,
    input  logic             i_spi_clk,
    input  logic             i_spi_copi,
    input  logic             i_spi_cs_n,
    output logic             o_spi_cipo,
    output logic             o_spi_cipo_oe
);

    localparam int CW = $clog2(WIDTH);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, copi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [WIDTH-1:0] hold_q, hold_d, tx_sh_q, tx_sh_d, load_word;
    logic             rx_dv_q, rx_dv_d, ready_q, ready_d, underrun_q, underrun_d;
    logic             cipo_q, cipo_d, busy_q, busy_d, word_end_q, word_end_d;

    logic sclk_s, cs_s, copi_s, cs_active, cs_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge, last_bit, word_start;

    // Reset values match the idle bus so leaving reset never looks like an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '1;
            copi_sync_q <= '0;
            sclk_prev_q <= CPOL;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], i_spi_copi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign copi_s      = copi_sync_q[SYNC_STAGES-1];
    assign cs_active   = ~cs_s;
    assign cs_fall     = cs_prev_q & ~cs_s;
    assign lead_edge   = cs_active && (sclk_prev_q == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = cs_active && (sclk_prev_q != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign last_bit    = sample_edge && (cnt_q == CW'(WIDTH - 1));
    // Mode CPHA=0 reloads on the shift edge after a full word, CPHA=1 on the last sample.
    assign word_start  = cs_fall || (CPHA ? last_bit : (shift_edge && word_end_q));

    always_comb begin
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_dv_d    = 1'b0;
        hold_d     = hold_q;
        ready_d    = ready_q;
        tx_sh_d    = tx_sh_q;
        cipo_d     = cipo_q;
        underrun_d = 1'b0;
        busy_d     = cs_active;
        word_end_d = word_end_q;
        load_word  = ready_q ? '0 : hold_q;

        if (!cs_active) begin
            cnt_d      = '0;
            rx_sh_d    = '0;
            tx_sh_d    = '0;
            cipo_d     = 1'b0;
            word_end_d = 1'b0;
        end else begin
            if (sample_edge) begin
                rx_sh_d = {rx_sh_q[WIDTH-2:0], copi_s};
                if (last_bit) begin
                    cnt_d      = '0;
                    rx_data_d  = rx_sh_d;
                    rx_dv_d    = 1'b1;
                    word_end_d = !CPHA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (shift_edge) begin
                word_end_d = 1'b0;
                if (!word_start) begin
                    cipo_d  = tx_sh_q[WIDTH-1];
                    tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                end
            end
            if (word_start) begin
                underrun_d = ready_q;
                ready_d    = 1'b1;
                if (CPHA) begin
                    tx_sh_d = load_word;
                end else begin
                    cipo_d  = load_word[WIDTH-1];
                    tx_sh_d = {load_word[WIDTH-2:0], 1'b0};
                end
            end
        end

        // The register frees up during a load, so a write in that cycle is taken.
        if (i_tx_dv && (ready_q || (cs_active && word_start))) begin
            hold_d  = i_tx_data;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_dv_q    <= 1'b0;
            hold_q     <= '0;
            ready_q    <= 1'b1;
            tx_sh_q    <= '0;
            cipo_q     <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
            word_end_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_dv_q    <= rx_dv_d;
            hold_q     <= hold_d;
            ready_q    <= ready_d;
            tx_sh_q    <= tx_sh_d;
            cipo_q     <= cipo_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
            word_end_q <= word_end_d;
        end
    end

    assign o_rx_data     = rx_data_q;
    assign o_rx_dv       = rx_dv_q;
    assign o_tx_ready    = ready_q;
    assign o_tx_underrun = underrun_q;
    assign o_busy        = busy_q;
    assign o_spi_cipo    = cipo_q;
    assign o_spi_cipo_oe = busy_q;

endmodule

// File: tb/tb_spi_peripheral_sync.sv
// Bench for spi_peripheral_sync: slot 0 is WIDTH=8 mode 0, slots 1..4 are WIDTH=16 modes 0..3.
// An SPI controller model drives each slot; a monitor scores received words from a queue.
module tb_spi_peripheral_sync;

    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  sclk = 5'b11000;
    logic [4:0]  cs_n = 5'b11111;
    logic [4:0]  copi = '0;
    logic [4:0]  tx_dv = '0;
    logic [15:0] txd = '0;
    wire  [4:0]  rx_dv, tx_ready, urun, busy, cipo, oe;
    logic [15:0] rxd [5];

    int tests = 0;
    int fails = 0;
    int cur = 0;
    int urun_cnt = 0;
    logic busy_seen;
    logic [15:0] exp_rx [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : 16;
        localparam int M = (g == 0) ? 0 : g - 1;
        localparam bit P_CPOL = (M / 2) != 0;
        localparam bit P_CPHA = (M % 2) != 0;
        wire [W-1:0] rxw;
        spi_peripheral_sync #(.WIDTH(W), .CPOL(P_CPOL), .CPHA(P_CPHA), .SYNC_STAGES(2)) u_dut (
            .i_clk(clk), .i_reset(rst),
            .o_rx_data(rxw), .o_rx_dv(rx_dv[g]),
            .i_tx_data(txd[W-1:0]), .i_tx_dv(tx_dv[g]),
            .o_tx_ready(tx_ready[g]), .o_tx_underrun(urun[g]), .o_busy(busy[g]),
            .i_spi_clk(sclk[g]), .i_spi_copi(copi[g]), .i_spi_cs_n(cs_n[g]),
            .o_spi_cipo(cipo[g]), .o_spi_cipo_oe(oe[g])
        );
        assign rxd[g] = 16'(rxw);
    end

    function automatic bit cpol_of(input int idx);
        return idx >= 3;
    endfunction
    function automatic bit cpha_of(input int idx);
        return idx == 2 || idx == 4;
    endfunction
    function automatic int width_of(input int idx);
        return (idx == 0) ? 8 : 16;
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every o_rx_dv pulse of the active slot must match the next expected word.
    logic prev_dv = 1'b0;
    always @(negedge clk) begin
        if (!rst && rx_dv[cur]) begin
            if (exp_rx.size() == 0) chk("rx_unexpected_dv", 1, 0);
            else chk("rx_data", 48'(rxd[cur]), 48'(exp_rx.pop_front()));
            chk("rx_dv_one_cycle", 48'(prev_dv), 0);
        end
        prev_dv = rx_dv[cur] & ~rst;
        if (!rst && urun[cur]) urun_cnt++;
    end

    task automatic write_tx(input int idx, input logic [15:0] d);
        txd = d;
        tx_dv[idx] = 1'b1;
        @(posedge clk); #1;
        tx_dv[idx] = 1'b0;
    endtask

    // Controller: nb bits MSB-first from mosi, captures CIPO at each sample point.
    // In CPHA=0 modes CS rises before SCLK returns to idle, so no trailing boundary edge.
    task automatic xfer(input int idx, input int nb, input logic [47:0] mosi, output logic [47:0] miso);
        bit pol = cpol_of(idx);
        bit pha = cpha_of(idx);
        miso = '0;
        cs_n[idx] = 1'b0;
        for (int i = nb - 1; i >= 0; i--) begin
            if (!pha) begin
                copi[idx] = mosi[i]; wcyc(H);
                miso = {miso[46:0], cipo[idx]};
                if (i == nb - 1) busy_seen = busy[idx];
                sclk[idx] = ~pol; wcyc(H);
                if (i == 0) begin cs_n[idx] = 1'b1; wcyc(H); end
                sclk[idx] = pol;
            end else begin
                if (i == nb - 1) wcyc(H);
                sclk[idx] = ~pol; copi[idx] = mosi[i]; wcyc(H);
                miso = {miso[46:0], cipo[idx]};
                if (i == nb - 1) busy_seen = busy[idx];
                sclk[idx] = pol; wcyc(H);
            end
        end
        if (pha) cs_n[idx] = 1'b1;
        wcyc(2 * H);
    endtask

    // One CS window of nw words; nwr writes: wr0 before the window, wr1 once the first word has started.
    task automatic run(input string tag, input int idx, input int nw, input logic [47:0] mosi,
                       input int nwr, input logic [15:0] wr0, input logic [15:0] wr1);
        int W = width_of(idx);
        int starts = nw + (cpha_of(idx) ? 1 : 0);
        logic [15:0] msk = (W == 8) ? 16'h00FF : 16'hFFFF;
        logic [15:0] wr [2];
        logic [47:0] miso;
        wr[0] = wr0 & msk;
        wr[1] = wr1 & msk;
        cur = idx;
        urun_cnt = 0;
        for (int w = 0; w < nw; w++) exp_rx.push_back(16'(mosi >> ((nw - 1 - w) * W)) & msk);
        if (nwr >= 1) write_tx(idx, wr[0]);
        fork
            xfer(idx, nw * W, mosi, miso);
            begin
                if (nwr == 2) begin
                    for (int k = 0; k < 300 && !tx_ready[idx]; k++) @(negedge clk);
                    if (!tx_ready[idx]) chk({tag, "_wait_first_load"}, 0, 1);
                    else begin @(posedge clk); #1; write_tx(idx, wr[1]); end
                end
            end
        join
        wcyc(4);
        for (int w = 0; w < nw; w++)
            chk({tag, "_cipo_word"}, 48'(16'(miso >> ((nw - 1 - w) * W)) & msk),
                48'((w < nwr) ? wr[w] : 16'h0));
        chk({tag, "_underruns"}, 48'(urun_cnt), 48'((starts > nwr) ? starts - nwr : 0));
        chk({tag, "_tx_ready_end"}, 48'(tx_ready[idx]), 48'(starts >= nwr));
        chk({tag, "_busy_in_window"}, 48'(busy_seen), 1);
        chk({tag, "_oe_idle"}, 48'(oe[idx]), 0);
        chk({tag, "_cipo_idle"}, 48'(cipo[idx]), 0);
        chk({tag, "_rx_pending"}, 48'(exp_rx.size()), 0);
        exp_rx.delete();
    endtask

    task automatic chk_reset_outputs(input string tag, input int idx);
        chk({tag, "_rx_data"}, 48'(rxd[idx]), 0);
        chk({tag, "_rx_dv"}, 48'(rx_dv[idx]), 0);
        chk({tag, "_tx_ready"}, 48'(tx_ready[idx]), 1);
        chk({tag, "_underrun"}, 48'(urun[idx]), 0);
        chk({tag, "_busy"}, 48'(busy[idx]), 0);
        chk({tag, "_cipo"}, 48'(cipo[idx]), 0);
        chk({tag, "_oe"}, 48'(oe[idx]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] miso;
        int glitch;
        wcyc(3);
        chk_reset_outputs("por", 0);
        rst = 1'b0;
        wcyc(4);

        run("mode0_w8", 0, 1, 48'h3C, 1, 16'hA5, 16'h0);
        for (int m = 1; m <= 4; m++)
            run("mode_w16", m, 1, 48'hBEEF, 1, 16'h1234, 16'h0);
        run("b2b", 0, 3, 48'h5AC3_96, 2, 16'h11, 16'h22);

        // Abort after 5 bits: no word, pad released, holding register consumed at CS fall.
        cur = 0; urun_cnt = 0;
        write_tx(0, 16'hFF);
        xfer(0, 5, 48'h1F, miso);
        wcyc(4);
        chk("abort_oe", 48'(oe[0]), 0);
        chk("abort_cipo", 48'(cipo[0]), 0);
        chk("abort_busy", 48'(busy[0]), 0);
        chk("abort_underrun", 48'(urun_cnt), 0);
        run("after_abort", 0, 1, 48'h96, 1, 16'hC3, 16'h0);

        // Handshake: 0x77 is offered continuously while 0x55 is held; it must only land at the load.
        cur = 0; urun_cnt = 0;
        write_tx(0, 16'h55);
        txd = 16'h77; tx_dv[0] = 1'b1;
        wcyc(5);
        chk("hs_held_not_ready", 48'(tx_ready[0]), 0);
        exp_rx.push_back(16'hE1); exp_rx.push_back(16'h4B);
        glitch = 0;
        fork
            xfer(0, 16, 48'hE14B, miso);
            begin
                repeat (2 * H + 4) begin
                    @(negedge clk);
                    if (tx_ready[0]) glitch++;
                end
                @(posedge clk); #1;
                tx_dv[0] = 1'b0;
            end
        join
        wcyc(4);
        chk("hs_ready_gap", 48'(glitch), 0);
        chk("hs_word0", 48'(miso[15:8]), 48'h55);
        chk("hs_word1", 48'(miso[7:0]), 48'h77);
        chk("hs_underruns", 48'(urun_cnt), 0);
        chk("hs_ready_end", 48'(tx_ready[0]), 1);
        chk("hs_rx_pending", 48'(exp_rx.size()), 0);
        exp_rx.delete();

        // Reset mid-word, held until the window closes; nothing may be received.
        cur = 0;
        write_tx(0, 16'h9A);
        fork
            xfer(0, 8, 48'hA7, miso);
            begin
                wcyc(3 * H + 2);
                #2 rst = 1'b1;
                #1 chk_reset_outputs("midreset", 0);
            end
        join
        wcyc(2);
        rst = 1'b0;
        wcyc(4);
        run("after_reset", 0, 1, 48'h6D, 1, 16'hB2, 16'h0);

        for (int r = 0; r < 8; r++) begin
            int idx = $urandom_range(0, 4);
            int nw = $urandom_range(1, 3);
            int nwr = $urandom_range(0, (nw > 2) ? 2 : nw);
            logic [47:0] mosi = {16'($urandom), 32'($urandom)};
            run("rand", idx, nw, mosi, nwr, 16'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
